scs8hd_pwrseq_4: RTL and testbench
==================================

# scs8hd_pwrseq_4

Power-domain sequencer for a switched scs8hd power island. It drives the isolation, retention save/restore and staged header-switch enables that bring the domain down and up. It exposes a single level request with an acknowledge. Banked switch enables limit in-rush current, and retention restore is suppressed when no valid save exists.

## Interface
Parameters:
- NBANK, 4: number of header-switch banks, range 1..16.
- STAGE_DLY, 3: cycles between consecutive bank transitions, and the settle time after the last bank; at least 1.
- SAVE_CYC, 2: width in cycles of the SAVE and RESTORE pulses; at least 1.

Ports:
- CLK, input, 1: sole clock, rising edge.
- RESET, input, 1: synchronous, active-high reset.
- PWR_REQ, input, 1: requested state, 1 = domain on, 0 = domain off.
- PWR_ACK, output, 1: 1 only while the domain is stably on.
- BUSY, output, 1: 1 in every transitional state.
- ISO, output, 1: isolation enable, 1 = outputs clamped.
- SAVE, output, 1: retention save pulse.
- RESTORE, output, 1: retention restore pulse.
- SW_EN, output, NBANK: per-bank header enables, 1 = bank conducting.
- vpwr, vgnd, vpb, vnb: inputs present only under SC_USE_PG_PIN; otherwise supply1/supply0 nets internally, unless `functional` is defined.

## Operation
- All outputs are registered. Reset values: PWR_ACK=0, BUSY=0, ISO=1, SAVE=0, RESTORE=0, SW_EN=0, state OFF, saved_valid=0.
- States:
  - OFF → SW_UP on PWR_REQ=1.
  - SW_UP: SW_EN[0] set on entry; bank i set STAGE_DLY·i cycles after entry; STAGE_DLY settle cycles follow the last bank.
  - After settle: go to RESTORE if saved_valid=1, else directly to ON.
  - RESTORE: RESTORE=1 for SAVE_CYC cycles, then ON.
  - ON: ISO=0, PWR_ACK=1.
  - ON → ISO_DN on PWR_REQ=0.
  - ISO_DN: ISO=1 for 1 cycle, then SAVE.
  - SAVE: SAVE=1 for SAVE_CYC cycles; saved_valid set on the final SAVE cycle; then SW_DN.
  - SW_DN: banks cleared highest index first, one every STAGE_DLY cycles, starting on entry; STAGE_DLY settle cycles, then OFF.
- PWR_REQ is sampled only in OFF and ON. Changes during a sequence are ignored, and the completed sequence is never aborted. A reversed request is honoured on the first cycle back in the stable state.
- ISO stays 1 in all states except ON. ISO is never 0 while any SW_EN bit is 0.
- RESET in any state forces the reset values on the next edge, including an abrupt clear of all banks. saved_valid is cleared, so the next power-up skips RESTORE.
- A single down-counter serves all timed intervals; its width is clog2(max(STAGE_DLY, SAVE_CYC)+1). A bank index register tracks the staged banks.

## Timing
Cycle numbers count from the edge that samples the request. Values below are for NBANK=4, STAGE_DLY=3, SAVE_CYC=2.
- Power-up, PWR_REQ=1 sampled at edge 0:
  - Edge 1: SW_EN=0001, BUSY=1.
  - Edges 4, 7, 10: SW_EN=0011, 0111, 1111.
  - With saved_valid=1: RESTORE=1 after edges 13 and 14; ISO=0, PWR_ACK=1, BUSY=0 after edge 15.
  - With saved_valid=0: ISO=0, PWR_ACK=1, BUSY=0 after edge 13.
- Power-down, PWR_REQ=0 sampled at edge 0:
  - Edge 1: ISO=1, PWR_ACK=0, BUSY=1.
  - Edges 2 and 3: SAVE=1.
  - Edges 4, 7, 10, 13: SW_EN=0111, 0011, 0001, 0000.
  - Edge 16: OFF, BUSY=0.
- General latencies:
  - Up: 1 + NBANK·STAGE_DLY (+SAVE_CYC if saved_valid) cycles.
  - Down: 2 + SAVE_CYC + NBANK·STAGE_DLY cycles.
- SAVE and RESTORE are never high together, and neither is high in ON or OFF.

## Structure
- Package scs8hd_pwrseq_pkg holds the state enum (OFF, SW_UP, RESTORE, ON, ISO_DN, SAVE, SW_DN) and the parameter-legality check function.
- Sub-module scs8hd_pwrseq_tmr: loadable down-counter with a zero flag, used for the STAGE_DLY and SAVE_CYC intervals.
- Top level contains the FSM, the bank index register, saved_valid and the output registers.

## Test plan
- Reset, then PWR_REQ=1 → SW_EN steps 0001/0011/0111/1111 at edges 1/4/7/10; no RESTORE; PWR_ACK=1 at edge 13.
- From ON, PWR_REQ=0 → ISO=1 at edge 1; SAVE high at edges 2–3; banks clear 1000-first at edges 4/7/10/13; BUSY=0 at edge 16.
- Power back up after a completed save → RESTORE high at edges 13–14; PWR_ACK=1 at edge 15.
- Toggle PWR_REQ 1→0 at edge 5 of a power-up → full up-sequence completes (PWR_ACK=1 at edge 13). The down-sequence then starts on the next sampled edge.
- Assert RESET at edge 8 of a power-down → next edge shows SW_EN=0, ISO=1, BUSY=0, state OFF. The following power-up skips RESTORE.
- Assertions throughout: ISO=0 implies SW_EN all ones; SAVE&RESTORE never both high; PWR_ACK implies !BUSY.

Source files
------------

// File: rtl/scs8hd_pwrseq_pkg.sv
// Shared types and parameter checks for the scs8hd power-island sequencer.
package scs8hd_pwrseq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SW_UP   = 3'd1,
    ST_RESTORE = 3'd2,
    ST_ON      = 3'd3,
    ST_ISO_DN  = 3'd4,
    ST_SAVE    = 3'd5,
    ST_SW_DN   = 3'd6
  } pwr_state_e;

  // True when the parameter set describes a buildable sequencer.
  function automatic bit pwrseq_params_ok(int nbank, int stage_dly, int save_cyc);
    return (nbank >= 1) && (nbank <= 16) && (stage_dly >= 1) && (save_cyc >= 1);
  endfunction

endpackage

// File: rtl/scs8hd_pwrseq_tmr.sv
// Loadable down-counter with zero flag; times bank steps, settle and pulses.
module scs8hd_pwrseq_tmr #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk_i) begin
    if (rst_i)              cnt_q <= '0;
    else if (ld_i)          cnt_q <= val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scs8hd_pwrseq_4.sv
// Power-domain sequencer: isolation, retention save/restore and staged
// header-switch banks for a switched scs8hd island.
module scs8hd_pwrseq_4
  import scs8hd_pwrseq_pkg::*;
#(
  parameter int NBANK     = 4,
  parameter int STAGE_DLY = 3,
  parameter int SAVE_CYC  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PWR_REQ,
  output logic             PWR_ACK,
  output logic             BUSY,
  output logic             ISO,
  output logic             SAVE,
  output logic             RESTORE,
  output logic [NBANK-1:0] SW_EN
`ifdef SC_USE_PG_PIN
  ,input logic             vpwr
  ,input logic             vgnd
  ,input logic             vpb
  ,input logic             vnb
`endif
);

  localparam int TMAX = (STAGE_DLY > SAVE_CYC) ? STAGE_DLY : SAVE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(NBANK + 1);
  localparam logic [BW-1:0] NB_L  = BW'(NBANK);
  localparam logic [TW-1:0] SD_LD = TW'(STAGE_DLY - 1);
  localparam logic [TW-1:0] SC_LD = TW'(SAVE_CYC - 1);

  if (!pwrseq_params_ok(NBANK, STAGE_DLY, SAVE_CYC)) begin : g_bad_param
    $error("scs8hd_pwrseq_4: illegal NBANK/STAGE_DLY/SAVE_CYC");
  end

`ifndef SC_USE_PG_PIN
`ifndef functional
  supply1 vpwr, vpb;
  supply0 vgnd, vnb;
`endif
`endif

  logic pg_ok;
`ifdef functional
  assign pg_ok = 1'b1;
`else
  assign pg_ok = vpwr & vpb & ~vgnd & ~vnb;
`endif

  pwr_state_e      state_q, state_d;
  logic [BW-1:0]   bnk_q, bnk_d;      // number of banks conducting
  logic            sv_q, sv_d;        // a valid retention save exists
  logic            tmr_ld, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic [NBANK-1:0] sw_nxt;

  logic             ack_q, busy_q, iso_q, save_q, rest_q;
  logic [NBANK-1:0] sw_q;

  scs8hd_pwrseq_tmr #(.W(TW)) u_tmr (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .ld_i   (tmr_ld),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  // Next-state: the request is only looked at in OFF and ON, so a started
  // sequence always runs to completion.
  always_comb begin
    state_d = state_q;
    bnk_d   = bnk_q;
    sv_d    = sv_q;
    tmr_ld  = 1'b0;
    tmr_val = SD_LD;
    unique case (state_q)
      ST_OFF: if (PWR_REQ) begin
        state_d = ST_SW_UP;
        bnk_d   = BW'(1);
        tmr_ld  = 1'b1;
      end
      ST_SW_UP: if (tmr_zero) begin
        if (bnk_q < NB_L) begin
          bnk_d  = bnk_q + 1'b1;
          tmr_ld = 1'b1;
        end else if (sv_q) begin
          state_d = ST_RESTORE;
          tmr_ld  = 1'b1;
          tmr_val = SC_LD;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_RESTORE: if (tmr_zero) state_d = ST_ON;
      ST_ON: if (!PWR_REQ) state_d = ST_ISO_DN;
      ST_ISO_DN: begin
        state_d = ST_SAVE;
        tmr_ld  = 1'b1;
        tmr_val = SC_LD;
      end
      ST_SAVE: if (tmr_zero) begin
        state_d = ST_SW_DN;
        sv_d    = 1'b1;
        bnk_d   = bnk_q - 1'b1;
        tmr_ld  = 1'b1;
      end
      ST_SW_DN: if (tmr_zero) begin
        if (bnk_q != '0) begin
          bnk_d  = bnk_q - 1'b1;
          tmr_ld = 1'b1;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Sequencer state, bank count and retention-valid flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_OFF;
      bnk_q   <= '0;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bnk_q   <= bnk_d;
      sv_q    <= sv_d;
    end
  end

  // Bank count to thermometer enables, lowest bank first.
  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    assign sw_nxt[i] = (bnk_q > BW'(i));
  end

  // Registered outputs decoded from the current state; ISO only drops in ON,
  // which is reached only with every bank conducting.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      iso_q  <= 1'b1;
      save_q <= 1'b0;
      rest_q <= 1'b0;
      sw_q   <= '0;
    end else begin
      ack_q  <= (state_q == ST_ON);
      busy_q <= (state_q != ST_ON) && (state_q != ST_OFF);
      iso_q  <= (state_q != ST_ON);
      save_q <= (state_q == ST_SAVE);
      rest_q <= (state_q == ST_RESTORE);
      sw_q   <= sw_nxt;
    end
  end

  assign PWR_ACK = ack_q;
  assign BUSY    = busy_q;
  assign ISO     = iso_q | ~pg_ok;   // clamp whenever rails are not good
  assign SAVE    = save_q;
  assign RESTORE = rest_q;
  assign SW_EN   = sw_q;

endmodule

// File: tb/tb_scs8hd_pwrseq_4.sv
// Bench for scs8hd_pwrseq_4: directed sequences plus random request/reset
// traffic, compared every cycle against a schedule-based model.
module tb_scs8hd_pwrseq_4;

  localparam int NB = 4;
  localparam int SD = 3;
  localparam int SC = 2;

  typedef struct packed {
    logic          ack;
    logic          busy;
    logic          iso;
    logic          save;
    logic          rest;
    logic [NB-1:0] sw;
  } out_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          PWR_REQ = 1'b0;
  logic          PWR_ACK, BUSY, ISO, SAVE, RESTORE;
  logic [NB-1:0] SW_EN;

  int checks = 0;
  int errors = 0;

  scs8hd_pwrseq_4 #(.NBANK(NB), .STAGE_DLY(SD), .SAVE_CYC(SC)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .PWR_REQ (PWR_REQ),
    .PWR_ACK (PWR_ACK),
    .BUSY    (BUSY),
    .ISO     (ISO),
    .SAVE    (SAVE),
    .RESTORE (RESTORE),
    .SW_EN   (SW_EN)
  );

  always #5 CLK = ~CLK;

  // ---------------- model: each accepted request expands into the full
  // list of per-edge output values the sequence must show.
  out_t q[$];
  out_t exp_o;
  bit   mdl_valid = 0;
  bit   mdl_on    = 0;
  bit   mdl_saved = 0;

  function automatic logic [NB-1:0] banks(int n);
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (i < n);
    return v;
  endfunction

  function automatic out_t off_out();
    out_t o;
    o = '0; o.iso = 1'b1;
    return o;
  endfunction

  function automatic out_t on_out();
    out_t o;
    o = '0; o.ack = 1'b1; o.sw = banks(NB);
    return o;
  endfunction

  task automatic push_up();
    int   len, n;
    out_t o;
    len = 1 + NB*SD + (mdl_saved ? SC : 0);
    for (int k = 1; k < len; k++) begin
      o = '0; o.busy = 1'b1; o.iso = 1'b1;
      n = (k - 1) / SD + 1;
      o.sw   = banks(n > NB ? NB : n);
      o.rest = mdl_saved && (k >= 1 + NB*SD);
      q.push_back(o);
    end
    q.push_back(on_out());
    mdl_on = 1;
  endtask

  task automatic push_down();
    int   len, n;
    out_t o;
    len = 2 + SC + NB*SD;
    for (int k = 1; k < len; k++) begin
      o = '0; o.busy = 1'b1; o.iso = 1'b1;
      o.save = (k >= 2) && (k < 2 + SC);
      if (k < 2 + SC) o.sw = banks(NB);
      else begin
        n = (k - 2 - SC) / SD + 1;
        o.sw = banks(NB - (n > NB ? NB : n));
      end
      q.push_back(o);
    end
    q.push_back(off_out());
    mdl_on    = 0;
    mdl_saved = 1;
  endtask

  task automatic model_step();
    if (RESET) begin
      q.delete();
      exp_o = off_out();
      mdl_on = 0; mdl_saved = 0; mdl_valid = 1;
      return;
    end
    if (!mdl_valid) return;
    if (q.size() > 0) begin
      exp_o = q.pop_front();
      if (q.size() != 0) return;
    end
    if (!mdl_on && PWR_REQ)      push_up();
    else if (mdl_on && !PWR_REQ) push_down();
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Compare process: model advances on each edge, DUT sampled 1 time unit later.
  bit stop_cmp = 0;
  initial begin
    out_t act;
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      if (stop_cmp) break;
      if (mdl_valid) begin
        act = {PWR_ACK, BUSY, ISO, SAVE, RESTORE, SW_EN};
        chk("model_outputs", int'(act), int'(exp_o));
        chk("iso_low_needs_all_banks", int'(!ISO && (SW_EN != {NB{1'b1}})), 0);
        chk("save_and_restore", int'(SAVE && RESTORE), 0);
        chk("ack_implies_not_busy", int'(PWR_ACK && BUSY), 0);
      end
    end
  end

  // ---------------- directed + random stimulus
  int cur;
  task automatic to_edge(int k);
    repeat (k - cur) @(posedge CLK);
    cur = k;
    #1;
  endtask

  task automatic start_seq(logic req);
    @(negedge CLK);
    PWR_REQ = req;
    @(posedge CLK);
    cur = 0;
  endtask

  initial begin
    RESET = 1'b1; PWR_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_iso", ISO, 1);
    chk("rst_busy_ack", {BUSY, PWR_ACK}, 0);
    chk("rst_sw", SW_EN, 0);
    @(negedge CLK); RESET = 1'b0;
    repeat (2) @(posedge CLK);

    // Cold power-up: no retention, so no RESTORE.
    start_seq(1'b1);
    to_edge(1);  chk("up_e1_sw", SW_EN, 4'b0001); chk("up_e1_busy", BUSY, 1);
    to_edge(4);  chk("up_e4_sw", SW_EN, 4'b0011);
    to_edge(7);  chk("up_e7_sw", SW_EN, 4'b0111);
    to_edge(10); chk("up_e10_sw", SW_EN, 4'b1111);
    to_edge(12); chk("up_e12_ack", PWR_ACK, 0);
    to_edge(13); chk("up_e13_ack", PWR_ACK, 1); chk("up_e13_iso", ISO, 0);
    repeat (3) @(posedge CLK);

    // Power-down with save.
    start_seq(1'b0);
    to_edge(1);  chk("dn_e1_iso_ack", {ISO, PWR_ACK}, 2'b10);
    to_edge(2);  chk("dn_e2_save", SAVE, 1);
    to_edge(3);  chk("dn_e3_save", SAVE, 1);
    to_edge(4);  chk("dn_e4_sw", SW_EN, 4'b0111); chk("dn_e4_save", SAVE, 0);
    to_edge(13); chk("dn_e13_sw", SW_EN, 4'b0000);
    to_edge(15); chk("dn_e15_busy", BUSY, 1);
    to_edge(16); chk("dn_e16_busy", BUSY, 0);
    repeat (2) @(posedge CLK);

    // Warm power-up: retention valid, RESTORE pulse expected.
    start_seq(1'b1);
    to_edge(12); chk("wup_e12_rest", RESTORE, 0);
    to_edge(13); chk("wup_e13_rest", RESTORE, 1);
    to_edge(14); chk("wup_e14_rest", RESTORE, 1);
    to_edge(15); chk("wup_e15_ack", PWR_ACK, 1); chk("wup_e15_rest", RESTORE, 0);
    repeat (2) @(posedge CLK);

    // Reset in the middle of a power-down.
    start_seq(1'b0);
    to_edge(7);
    @(negedge CLK); RESET = 1'b1;
    to_edge(8);
    chk("rst_mid_sw", SW_EN, 0); chk("rst_mid_iso", ISO, 1); chk("rst_mid_busy", BUSY, 0);
    @(negedge CLK); RESET = 1'b0;
    repeat (2) @(posedge CLK);

    // Power-up after reset skips RESTORE; a drop of the request mid-way is
    // only seen once ON is reached.
    start_seq(1'b1);
    to_edge(4);
    @(negedge CLK); PWR_REQ = 1'b0;
    to_edge(13); chk("tog_e13_ack", PWR_ACK, 1); chk("tog_e13_busy", BUSY, 0);
    to_edge(14); chk("tog_e14_ack", PWR_ACK, 0); chk("tog_e14_iso", ISO, 1);
    chk("tog_e14_busy", BUSY, 1);
    repeat (20) @(posedge CLK);

    // Random request/reset traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(11) == 0) PWR_REQ = ~PWR_REQ;
      RESET = ($urandom_range(399) == 0);
    end
    @(negedge CLK); RESET = 1'b0;
    repeat (3) @(posedge CLK);
    stop_cmp = 1;
    @(posedge CLK); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
